// File: rtl/menu_button_conditioner_pkg.sv
// Shared definitions for the menu button conditioner: channel state encoding,
// production timing defaults, reduced simulation timings and button indices.
package menu_button_conditioner_pkg;

  // Per-channel debounce/auto-repeat states.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } chan_state_t;

  // Production timing at 50 MHz: 20 ms debounce, 500 ms repeat delay,
  // 200 ms repeat period.
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;
  localparam int DEF_CNT_WIDTH       = 25;

  // Shortened timing so a simulation can exercise every state in a few cycles.
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 10;
  localparam int SIM_REPEAT_PERIOD   = 5;
  localparam int SIM_CNT_WIDTH       = 8;

  // Bit positions of each button inside BTN_HELD.
  localparam int NUM_BUTTONS   = 3;
  localparam int BTN_IDX_UP    = 0;
  localparam int BTN_IDX_DOWN  = 1;
  localparam int BTN_IDX_START = 2;

  // A button counts as held from the accepted press until the release is
  // accepted, including while a release is still being debounced.
  function automatic logic is_held_state(input chan_state_t s);
    return (s == HELD) || (s == REPEAT) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with optional
// auto-repeat, and registered press pulse / held level outputs.
module btn_debounce_channel
  import menu_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic MP_CLOCK_50,
  input  logic MP_RESET,
  input  logic btn_n,
  output logic press_pulse,
  output logic btn_held
);

  localparam logic [CNT_WIDTH-1:0] DEBOUNCE_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST    = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST   = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

  logic [1:0]           sync_ff;
  logic                 pressed;
  chan_state_t          state;
  chan_state_t          next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 from_repeat;
  logic                 from_repeat_next;
  logic                 debounce_done;
  logic                 delay_done;
  logic                 period_done;
  logic                 pulse_next;
  logic                 held_next;

  // Invert the raw active-low button and bring it into the clock domain; a
  // cleared synchronizer therefore reads as "released".
  always_ff @(posedge MP_CLOCK_50 or posedge MP_RESET) begin
    if (MP_RESET) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], ~btn_n};
    end
  end

  assign pressed       = sync_ff[1];
  assign debounce_done = (cnt == DEBOUNCE_LAST);
  assign delay_done    = (cnt == DELAY_LAST);
  assign period_done   = (cnt == PERIOD_LAST);

  // State, counter and repeat-origin registers.
  always_ff @(posedge MP_CLOCK_50 or posedge MP_RESET) begin
    if (MP_RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      from_repeat <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      from_repeat <= from_repeat_next;
    end
  end

  // Next-state and counter logic; the counter measures how long the current
  // level has been stable, or how long the button has been held.
  always_comb begin
    next_state       = state;
    cnt_next         = cnt;
    from_repeat_next = from_repeat;
    unique case (state)
      IDLE: begin
        cnt_next         = '0;
        from_repeat_next = 1'b0;
        if (pressed) begin
          next_state = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (debounce_done) begin
          next_state       = HELD;
          cnt_next         = '0;
          from_repeat_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!pressed) begin
          next_state = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (REPEAT_EN) begin
          if (delay_done) begin
            next_state       = REPEAT;
            cnt_next         = '0;
            from_repeat_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end
      REPEAT: begin
        if (!pressed) begin
          next_state = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (period_done) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          next_state = from_repeat ? REPEAT : HELD;
          cnt_next   = '0;
        end else if (debounce_done) begin
          next_state       = IDLE;
          cnt_next         = '0;
          from_repeat_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        next_state       = IDLE;
        cnt_next         = '0;
        from_repeat_next = 1'b0;
      end
    endcase
  end

  // Output decode: a pulse on the accepted press and on each repeat tick; a
  // pulse already on the output blocks the next one so a degenerate
  // REPEAT_PERIOD of 1 still cannot produce back-to-back pulse cycles.
  always_comb begin
    pulse_next = 1'b0;
    held_next  = is_held_state(next_state);
    if (pressed) begin
      unique case (state)
        PRESS_WAIT: pulse_next = debounce_done;
        HELD:       pulse_next = REPEAT_EN && delay_done;
        REPEAT:     pulse_next = period_done;
        default:    pulse_next = 1'b0;
      endcase
    end
    if (press_pulse) begin
      pulse_next = 1'b0;
    end
  end

  // Registered outputs so the menu FSM sees glitch-free signals.
  always_ff @(posedge MP_CLOCK_50 or posedge MP_RESET) begin
    if (MP_RESET) begin
      press_pulse <= 1'b0;
      btn_held    <= 1'b0;
    end else begin
      press_pulse <= pulse_next;
      btn_held    <= held_next;
    end
  end

endmodule

// File: rtl/menu_button_conditioner.sv
// Menu button conditioner: three independent debounce channels turning the
// raw UP/DOWN/START buttons into one-cycle press pulses and held levels.
module menu_button_conditioner
  import menu_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                   MP_CLOCK_50,
  input  logic                   MP_RESET,
  input  logic                   BTN_UP_N,
  input  logic                   BTN_DOWN_N,
  input  logic                   BTN_START_N,
  output logic                   MP_UP,
  output logic                   MP_DOWN,
  output logic                   MP_START,
  output logic [NUM_BUTTONS-1:0] BTN_HELD
);

  logic held_up;
  logic held_down;
  logic held_start;

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_WIDTH       (CNT_WIDTH),
    .REPEAT_EN       (1'b1)
  ) u_up (
    .MP_CLOCK_50 (MP_CLOCK_50),
    .MP_RESET    (MP_RESET),
    .btn_n       (BTN_UP_N),
    .press_pulse (MP_UP),
    .btn_held    (held_up)
  );

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_WIDTH       (CNT_WIDTH),
    .REPEAT_EN       (1'b1)
  ) u_down (
    .MP_CLOCK_50 (MP_CLOCK_50),
    .MP_RESET    (MP_RESET),
    .btn_n       (BTN_DOWN_N),
    .press_pulse (MP_DOWN),
    .btn_held    (held_down)
  );

  // START confirms a menu choice, so holding it must never auto-repeat.
  btn_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_WIDTH       (CNT_WIDTH),
    .REPEAT_EN       (1'b0)
  ) u_start (
    .MP_CLOCK_50 (MP_CLOCK_50),
    .MP_RESET    (MP_RESET),
    .btn_n       (BTN_START_N),
    .press_pulse (MP_START),
    .btn_held    (held_start)
  );

  assign BTN_HELD[BTN_IDX_UP]    = held_up;
  assign BTN_HELD[BTN_IDX_DOWN]  = held_down;
  assign BTN_HELD[BTN_IDX_START] = held_start;

endmodule
